instruction_memory_sync: RTL



---
 rtl/instruction_memory_sync_pkg.sv | 21 ++
 rtl/imem_array.sv | 28 ++
 rtl/instruction_memory_sync.sv | 127 ++++++++++++
 3 files changed

// File: rtl/instruction_memory_sync_pkg.sv
// Shared definitions for the synchronous instruction memory:
// FSM encodings, default depth and the assembler words it relies on.
package instruction_memory_sync_pkg;

    typedef enum logic {
        IMEM_CLEAR = 1'b0,
        IMEM_READY = 1'b1
    } imem_state_e;

    localparam int IMEM_DEPTH_DEFAULT = 64;

    localparam logic [15:0] ASM_NOP = 16'hF000;

    // ADDIU rt <- rs + imm : opcode 4'h4, rs[2:0], rt[2:0], imm[5:0]
    function automatic logic [15:0] asm_addiu(input logic [2:0] rs,
                                              input logic [2:0] rt,
                                              input logic [5:0] imm);
        return {4'h4, rs, rt, imm};
    endfunction

endpackage

// File: rtl/imem_array.sv
// Simple dual-port synchronous RAM: one write port, one registered read port
// with read enable so the output holds between reads. No reset on storage.
module imem_array #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instruction_memory_sync.sv
// Clocked instruction memory: NOP clear after reset, 1-cycle registered fetch,
// runtime program load with priority over fetch, out-of-range fault reporting.
module instruction_memory_sync
    import instruction_memory_sync_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               DEPTH    = IMEM_DEPTH_DEFAULT,
    parameter int               ADDR_W   = 16,
    parameter logic [WIDTH-1:0] NOP_WORD = WIDTH'(ASM_NOP)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              instr_valid,
    output logic [WIDTH-1:0]  instr,
    output logic              fetch_fault,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [WIDTH-1:0]  load_data,
    output logic              load_err,
    output logic              busy
);

    localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [AW-1:0]   LAST      = AW'(DEPTH - 1);

    imem_state_e      state, state_next;
    logic [AW-1:0]    cnt, cnt_next;

    logic             fetch_in_range;
    logic             load_in_range;
    logic             fetch_accept;

    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic             ram_re;
    logic [WIDTH-1:0] rdata_p1;

    logic             vld_p1;
    logic             fault_p1;
    logic             nop_sel_p1;

    // Full-width unsigned compare: high address bits never alias into the array.
    assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_EXT;
    assign load_in_range  = {1'b0, load_addr}  < DEPTH_EXT;
    assign fetch_accept   = fetch_req && fetch_ready;
    assign ram_re         = fetch_accept && fetch_in_range;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IMEM_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        busy        = 1'b0;
        fetch_ready = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = load_addr[AW-1:0];
        ram_wdata   = load_data;
        case (state)
            IMEM_CLEAR: begin
                busy      = 1'b1;
                ram_we    = 1'b1;
                ram_waddr = cnt;
                ram_wdata = NOP_WORD;
                if (cnt == LAST) begin
                    state_next = IMEM_READY;
                end else begin
                    cnt_next = cnt + AW'(1);
                end
            end
            IMEM_READY: begin
                fetch_ready = !load_en;
                ram_we      = load_en && load_in_range;
            end
            default: state_next = IMEM_CLEAR;
        endcase
    end

    imem_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (fetch_addr[AW-1:0]),
        .rdata (rdata_p1)
    );

    // ---- stage p1: fetch result, aligned with the RAM read register ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            fault_p1   <= 1'b0;
            nop_sel_p1 <= 1'b1;
            load_err   <= 1'b0;
        end else begin
            vld_p1   <= fetch_accept;
            fault_p1 <= fetch_accept && !fetch_in_range;
            load_err <= (state == IMEM_READY) && load_en && !load_in_range;
            if (fetch_accept) begin
                nop_sel_p1 <= !fetch_in_range;
            end
        end
    end

    // The RAM register only updates on in-range fetches, so instr holds between fetches.
    assign instr_valid = vld_p1;
    assign fetch_fault = fault_p1;
    assign instr       = nop_sel_p1 ? NOP_WORD : rdata_p1;

endmodule
